alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FLAGS_EN to latch and return the ALU compare flags.
module alu_arbiter #(
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_func,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_func,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic [2:0]  rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic [2:0]  rsp1_flags,
    output logic [3:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_eq,
    input  logic        alu_lt,
    input  logic        alu_ltu
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  func_q, func_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        gnt0, gnt1, idle, accept, owner_rdy;

    always_comb begin
        gnt0      = req0_valid & (~req1_valid | ~ptr_q);
        gnt1      = req1_valid & (~req0_valid | ptr_q);
        idle      = (state_q == IDLE) & ~rst;
        accept    = idle & (gnt0 | gnt1);
        owner_rdy = owner_q ? rsp1_ready : rsp0_ready;
        state_d   = (state_q == IDLE) ? (accept ? EXEC : IDLE) :
                    (state_q == EXEC) ? RESP :
                    (state_q == RESP) ? (owner_rdy ? IDLE : RESP) : IDLE;
        // Winner 0 hands priority to 1 and vice versa, so ptr_d equals gnt0.
        ptr_d     = accept ? gnt0 : ptr_q;
        owner_d   = accept ? gnt1 : owner_q;
        func_d    = accept ? (gnt1 ? req1_func : req0_func) : func_q;
        a_d       = accept ? (gnt1 ? req1_a : req0_a) : a_q;
        b_d       = accept ? (gnt1 ? req1_b : req0_b) : b_q;
        res_d     = (state_q == EXEC) ? alu_out : res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= RESET_PRIO[0];
            owner_q <= 1'b0;
            func_q  <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [2:0] flags_q, flags_d;

    always_comb flags_d = (state_q == EXEC) ? {alu_eq, alu_lt, alu_ltu} : flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= 3'd0;
        else     flags_q <= flags_d;
    end

    assign rsp0_flags = flags_q;
    assign rsp1_flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{alu_eq, alu_lt, alu_ltu};
    assign rsp0_flags   = 3'd0;
    assign rsp1_flags   = 3'd0;
`endif

    assign req0_ready = idle & gnt0;
    assign req1_ready = idle & gnt1;
    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign alu_func   = func_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    localparam int RESET_PRIO = 0;
`ifdef ALU_ARB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [3:0]  req0_func = 0, req1_func = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp0_data, rsp1_data;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [3:0]  alu_func;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_eq, alu_lt, alu_ltu;
    int          checks = 0, errors = 0;
    int          mptr = RESET_PRIO;

    always #5 clk = ~clk;

    alu_arbiter #(.RESET_PRIO(RESET_PRIO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
        .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return (a + b) & ~32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // The shared ALU seen by the DUT.
    always_comb begin
        alu_out = alu_ref(alu_func, alu_a, alu_b);
        alu_eq  = alu_a == alu_b;
        alu_lt  = $signed(alu_a) < $signed(alu_b);
        alu_ltu = alu_a < alu_b;
    end

    // Offers one request pattern at a negedge and follows any granted operation to completion.
    task automatic run_op(input bit v0, input bit v1, input logic [3:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [3:0] f1, input logic [31:0] a1, input logic [31:0] b1, input int stall);
        int          w;
        logic [1:0]  erdy, ersp;
        logic [3:0]  ef;
        logic [31:0] ea, eb, ed;
        logic [2:0]  efl;
        w = (v0 && v1) ? mptr : v0 ? 0 : v1 ? 1 : -1;
        erdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        req0_valid = v0; req0_func = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_func = f1; req1_a = a1; req1_b = b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== erdy) begin
            errors++; $display("FAIL grant ready=%b expected=%b", {req1_ready, req0_ready}, erdy);
        end
        if (w < 0) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
                errors++; $display("FAIL idle_rsp valid=%b expected=00", {rsp1_valid, rsp0_valid});
            end
            return;
        end
        ef = w ? f1 : f0; ea = w ? a1 : a0; eb = w ? b1 : b0;
        ed = alu_ref(ef, ea, eb);
        efl = FLAGS ? {ea == eb, $signed(ea) < $signed(eb), ea < eb} : 3'b000;
        ersp = w ? 2'b10 : 2'b01;
        mptr = 1 - w;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000 || {alu_func, alu_a, alu_b} !== {ef, ea, eb}) begin
            errors++;
            $display("FAIL exec rdy/rsp=%b alu=%h/%h/%h expected 0000 %h/%h/%h",
                     {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, alu_func, alu_a, alu_b, ef, ea, eb);
        end
        req0_func = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
        req1_func = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            checks++;
            if ({rsp1_valid, rsp0_valid} !== ersp || rsp0_data !== ed || rsp1_data !== ed ||
                rsp0_flags !== efl || rsp1_flags !== efl || {req1_ready, req0_ready} !== 2'b00 ||
                {alu_func, alu_a, alu_b} !== {ef, ea, eb}) begin
                errors++;
                $display("FAIL resp[%0d] valid=%b data=%h/%h flags=%b/%b rdy=%b alu=%h/%h/%h expected valid=%b data=%h flags=%b rdy=00 alu=%h/%h/%h",
                         i, {rsp1_valid, rsp0_valid}, rsp0_data, rsp1_data, rsp0_flags, rsp1_flags,
                         {req1_ready, req0_ready}, alu_func, alu_a, alu_b, ersp, ed, efl, ef, ea, eb);
            end
            if (w == 0) begin rsp0_ready = (i == stall); rsp1_ready = 1'($urandom); end
            else        begin rsp1_ready = (i == stall); rsp0_ready = 1'($urandom); end
            @(posedge clk); @(negedge clk);
        end
        rsp0_ready = 0; rsp1_ready = 0; req0_valid = 0; req1_valid = 0;
        #1;
        checks++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            errors++; $display("FAIL resp_exit valid=%b expected=00", {rsp1_valid, rsp0_valid});
        end
    endtask

    task automatic test_reset;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk); #1;
        checks++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000 || {rsp0_data, rsp1_data} !== 64'd0 ||
            {rsp0_flags, rsp1_flags} !== 6'd0 || {alu_func, alu_a, alu_b} !== 68'd0) begin
            errors++;
            $display("FAIL reset rdy/rsp=%b data=%h/%h flags=%b/%b alu=%h/%h/%h expected all zero",
                     {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, rsp0_data, rsp1_data,
                     rsp0_flags, rsp1_flags, alu_func, alu_a, alu_b);
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); rst = 0;
        mptr = RESET_PRIO;
    endtask

    task automatic test_single_op;
        run_op(1, 0, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);
        run_op(0, 1, 4'd12, 32'h1234, 32'h5678, 4'd12, 32'h1234, 32'h5678, 1);
    endtask

    task automatic test_contention;
        run_op(1, 1, 4'd1, 32'd10, 32'd3, 4'd5, 32'hF0, 32'hFF, 0);
        run_op(1, 1, 4'd1, 32'd10, 32'd3, 4'd5, 32'hF0, 32'hFF, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            run_op(1, 1, 4'($urandom_range(0, 10)), $urandom, $urandom, 4'($urandom_range(0, 10)), $urandom, $urandom, 0);
    endtask

    task automatic test_backpressure;
        run_op(0, 1, 4'd0, 32'd0, 32'd0, 4'd3, 32'hFFFFFFFF, 32'd1, 5);
    endtask

    task automatic test_flags;
        run_op(1, 0, 4'd0, 32'h80000000, 32'h80000000, 4'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic test_reset_mid_op;
        req0_valid = 1; req0_func = 4'd10; req0_a = 32'h1001; req0_b = 32'd2;
        @(posedge clk); @(negedge clk);
        rst = 1; #1;
        checks++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000 || {rsp0_data, rsp1_data} !== 64'd0 ||
            {rsp0_flags, rsp1_flags} !== 6'd0 || {alu_func, alu_a, alu_b} !== 68'd0) begin
            errors++;
            $display("FAIL reset_mid rdy/rsp=%b data=%h flags=%b alu=%h/%h/%h expected all zero",
                     {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, rsp0_data, rsp0_flags, alu_func, alu_a, alu_b);
        end
        req0_valid = 0;
        @(posedge clk); @(negedge clk);
        rst = 0;
        mptr = RESET_PRIO;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({rsp1_valid, rsp0_valid} !== 2'b00 || rsp0_data !== 32'd0) begin
                errors++; $display("FAIL reset_mid_rsp[%0d] valid=%b data=%h expected 00/0", i, {rsp1_valid, rsp0_valid}, rsp0_data);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a0, a1;
        for (int i = 0; i < 40; i++) begin
            a0 = $urandom; a1 = $urandom;
            run_op(1'($urandom), 1'($urandom), 4'($urandom), a0, ($urandom_range(0, 3) == 0) ? a0 : $urandom,
                   4'($urandom), a1, ($urandom_range(0, 3) == 0) ? a1 : $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single_op;
        test_reset_mid_op;
        test_contention;
        test_back_to_back;
        test_backpressure;
        test_flags;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
